multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle sequencing controller for the MIPS datapath. It walks each instruction through FETCH, DECODE, EXEC, MEM and WB using the 6-bit instruction code produced by the instruction decoder (`instr.vh` codes: addu, subu, jr, sll, ori, lw, sw, beq, lui, jal). It drives all datapath enables and mux selects, and it owns the single shared memory port's request/acknowledge handshake for both instruction fetch and data access.

## Interface
Parameters:
- `RESET_STATE`, default 3'd0 (FETCH): state entered on reset. Fixed at FETCH in all builds.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `instrCode_in`  in  6  decoded instruction code. Valid from DECODE onward.
- `zero_in`  in  1  ALU equality flag, sampled in EXEC.
- `mem_ack_in`  in  1  memory completion, one cycle per request.
- `mem_req_out`  out  1  memory request, held until ack.
- `mem_we_out`  out  1  memory write (sw only).
- `pcWrite_out`, `irWrite_out`, `regWrite_out`  out  1 each  register enables.
- `pcSrc_out`  out  2  0 = PC+4, 1 = branch target, 2 = jump target, 3 = rs.
- `regDst_out`  out  2  0 = rt, 1 = rd, 2 = $31.
- `memToReg_out`  out  2  0 = ALU, 1 = memory data, 2 = PC (already +4).
- `aluSrc_out`  out  1  0 = rt, 1 = extended immediate.
- `extOp_out`  out  1  0 = zero-extend, 1 = sign-extend.
- `aluOp_out`  out  3  0 = add, 1 = sub, 2 = or, 3 = lui, 4 = sll.
- `state_out`  out  3  current state, registered.
- `done_out`  out  1  one-cycle pulse on the retiring cycle.
- `cycle_cnt_out`, `retire_cnt_out`  out  32 each  performance counters (see Configuration).

## Operation
- State encoding: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4. Codes 5–7 are unreachable and transition to FETCH.
- **FETCH:** `mem_req_out` = 1, `mem_we_out` = 0. Stay in FETCH while `mem_ack_in` = 0. On ack: `irWrite_out` = 1, `pcWrite_out` = 1, `pcSrc_out` = 0, then go to DECODE.
- **DECODE:**
  - jal: `pcWrite_out` = 1, `pcSrc_out` = 2, `regWrite_out` = 1, `regDst_out` = 2, `memToReg_out` = 2, `done_out` = 1, then FETCH.
  - jr: `pcWrite_out` = 1, `pcSrc_out` = 3, `done_out` = 1, then FETCH.
  - Unknown code: no writes, `done_out` = 1, then FETCH.
  - All other codes: go to EXEC.
- **EXEC:** `aluOp_out`, `aluSrc_out` and `extOp_out` are set per instruction:
  - addu, lw, sw: add; lw and sw use imm with sign-extend.
  - subu, beq: sub.
  - ori: or, imm, zero-extend.
  - lui: lui, imm.
  - sll: sll.
  - Next state: beq asserts `pcWrite_out` = `zero_in` with `pcSrc_out` = 1 and `done_out` = 1, then FETCH. lw and sw go to MEM. Everything else goes to WB.
- **MEM:** `mem_req_out` = 1, `mem_we_out` = 1 for sw. Stay in MEM until ack. On ack, sw asserts `done_out` and goes to FETCH; lw goes to WB.
- **WB:** `regWrite_out` = 1.
  - Register select: `regDst_out` = 1 for addu, subu, sll; 0 otherwise.
  - Write data: `memToReg_out` = 1 for lw; 0 otherwise.
  - `done_out` = 1, then FETCH.
- ALU control (`aluOp_out`, `aluSrc_out`, `extOp_out`) is also held in WB and MEM.
- All outputs not listed for a state are 0.
- `instrCode_in` and `mem_ack_in` are ignored outside the states that name them. An ack arriving outside FETCH or MEM has no effect.

## Timing
- `state_out` is the only registered control output. All others are combinational from state, `instrCode_in`, `zero_in` and `mem_ack_in`.
- Latency per instruction with zero-wait memory (ack in the first request cycle):
  - jal, jr: 2 cycles.
  - beq: 3 cycles.
  - addu, subu, ori, lui, sll, sw: 4 cycles.
  - lw: 5 cycles.
- Each memory wait cycle adds 1 cycle.
- Reset is asynchronous: the state goes to FETCH immediately, and counters clear to 0. Consequences:
  - `mem_req_out` reads 1 (FETCH) during reset, but the memory must ignore requests while reset is high.
  - All other outputs read 0 during reset.
  - Reset during MEM abandons the access; no register or PC write occurs.
- First fetch: on the first rising edge after reset deassertion, the state is FETCH and the request is already asserted.

## Configuration
- `MULTICYCLE_CTRL_PERF_EN` defined:
  - `cycle_cnt_out` increments every cycle after reset.
  - `retire_cnt_out` increments on each `done_out`.
  - Both wrap modulo 2^32.
- Not defined: both counter ports are tied to 0 and no counter flops exist. The port list is identical in both builds.

## Test plan
- Reset asserted mid-MEM of sw with ack pending -> `state_out` = 0 asynchronously, `mem_we_out` = 0, and no write occurs after deassert.
- addu with `mem_ack_in` = 1 in the first fetch cycle -> states 0,1,2,4 then 0; `regWrite_out` = 1 with `regDst_out` = 1 in cycle 4; `done_out` pulses once.
- lw with fetch ack delayed 2 cycles and data ack delayed 1 cycle -> 8 cycles total; WB shows `memToReg_out` = 1 and `regDst_out` = 0.
- beq with `zero_in` = 1, then beq with `zero_in` = 0 -> EXEC shows `pcWrite_out` = 1 with `pcSrc_out` = 1 for the first and `pcWrite_out` = 0 for the second; 3 cycles each.
- jal -> DECODE asserts `pcSrc_out` = 2, `regDst_out` = 2 and `memToReg_out` = 2, then returns to FETCH; unknown code 6'h3F -> DECODE then FETCH with no writes.
- With `MULTICYCLE_CTRL_PERF_EN` defined, run 10 zero-wait addu -> `retire_cnt_out` = 10, `cycle_cnt_out` = 40; without the macro both read 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for the multi-cycle MIPS datapath (optional counters: MULTICYCLE_CTRL_PERF_EN)
module multicycle_ctrl #(
  parameter logic [2:0] RESET_STATE = 3'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  instrCode_in,
  input  logic        zero_in,
  input  logic        mem_ack_in,
  output logic        mem_req_out,
  output logic        mem_we_out,
  output logic        pcWrite_out,
  output logic        irWrite_out,
  output logic        regWrite_out,
  output logic [1:0]  pcSrc_out,
  output logic [1:0]  regDst_out,
  output logic [1:0]  memToReg_out,
  output logic        aluSrc_out,
  output logic        extOp_out,
  output logic [2:0]  aluOp_out,
  output logic [2:0]  state_out,
  output logic        done_out,
  output logic [31:0] cycle_cnt_out,
  output logic [31:0] retire_cnt_out
);
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [5:0] I_ADDU = 6'd1;
  localparam logic [5:0] I_SUBU = 6'd2;
  localparam logic [5:0] I_JR   = 6'd3;
  localparam logic [5:0] I_SLL  = 6'd4;
  localparam logic [5:0] I_ORI  = 6'd5;
  localparam logic [5:0] I_LW   = 6'd6;
  localparam logic [5:0] I_SW   = 6'd7;
  localparam logic [5:0] I_BEQ  = 6'd8;
  localparam logic [5:0] I_LUI  = 6'd9;
  localparam logic [5:0] I_JAL  = 6'd10;
  logic [2:0] r_state;
  logic [2:0] w_next;
  logic       w_ack;
  logic       w_addu, w_subu, w_jr, w_sll, w_ori, w_lw, w_sw, w_beq, w_lui, w_jal;
  logic       w_known;
  logic [2:0] w_alu_op;
  logic       w_alu_src, w_ext;
  // an ack seen while reset is high must not open any write enable
  assign w_ack   = mem_ack_in & ~reset;
  assign w_addu  = instrCode_in == I_ADDU;
  assign w_subu  = instrCode_in == I_SUBU;
  assign w_jr    = instrCode_in == I_JR;
  assign w_sll   = instrCode_in == I_SLL;
  assign w_ori   = instrCode_in == I_ORI;
  assign w_lw    = instrCode_in == I_LW;
  assign w_sw    = instrCode_in == I_SW;
  assign w_beq   = instrCode_in == I_BEQ;
  assign w_lui   = instrCode_in == I_LUI;
  assign w_jal   = instrCode_in == I_JAL;
  assign w_known = w_addu | w_subu | w_sll | w_ori | w_lw | w_sw | w_beq | w_lui;
  assign w_alu_op  = (w_subu | w_beq) ? 3'd1 : w_ori ? 3'd2 : w_lui ? 3'd3 : w_sll ? 3'd4 : 3'd0;
  assign w_alu_src = w_lw | w_sw | w_ori | w_lui;
  assign w_ext     = w_lw | w_sw;
  assign state_out = r_state;
  // state register, forced to FETCH asynchronously
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= RESET_STATE;
    else       r_state <= w_next;
  // per-state control decode and next-state selection
  always_comb begin
    w_next       = S_FETCH;
    mem_req_out  = 1'b0;
    mem_we_out   = 1'b0;
    pcWrite_out  = 1'b0;
    irWrite_out  = 1'b0;
    regWrite_out = 1'b0;
    pcSrc_out    = 2'd0;
    regDst_out   = 2'd0;
    memToReg_out = 2'd0;
    aluSrc_out   = 1'b0;
    extOp_out    = 1'b0;
    aluOp_out    = 3'd0;
    done_out     = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req_out = 1'b1;
        irWrite_out = w_ack;
        pcWrite_out = w_ack;
        w_next      = w_ack ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        pcWrite_out  = w_jal | w_jr;
        pcSrc_out    = w_jal ? 2'd2 : w_jr ? 2'd3 : 2'd0;
        regWrite_out = w_jal;
        regDst_out   = w_jal ? 2'd2 : 2'd0;
        memToReg_out = w_jal ? 2'd2 : 2'd0;
        done_out     = ~w_known;
        w_next       = w_known ? S_EXEC : S_FETCH;
      end
      S_EXEC: begin
        aluOp_out   = w_alu_op;
        aluSrc_out  = w_alu_src;
        extOp_out   = w_ext;
        pcWrite_out = w_beq & zero_in;
        pcSrc_out   = w_beq ? 2'd1 : 2'd0;
        done_out    = w_beq;
        w_next      = w_beq ? S_FETCH : (w_lw | w_sw) ? S_MEM : S_WB;
      end
      S_MEM: begin
        aluOp_out   = w_alu_op;
        aluSrc_out  = w_alu_src;
        extOp_out   = w_ext;
        mem_req_out = 1'b1;
        mem_we_out  = w_sw;
        done_out    = w_ack & w_sw;
        w_next      = ~w_ack ? S_MEM : w_sw ? S_FETCH : S_WB;
      end
      S_WB: begin
        aluOp_out    = w_alu_op;
        aluSrc_out   = w_alu_src;
        extOp_out    = w_ext;
        regWrite_out = 1'b1;
        regDst_out   = (w_addu | w_subu | w_sll) ? 2'd1 : 2'd0;
        memToReg_out = w_lw ? 2'd1 : 2'd0;
        done_out     = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] r_cycle_cnt, r_retire_cnt;
  // free-running cycle and retirement counters, wrapping at 2^32
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_cycle_cnt  <= 32'd0;
      r_retire_cnt <= 32'd0;
    end else begin
      r_cycle_cnt  <= r_cycle_cnt + 32'd1;
      r_retire_cnt <= r_retire_cnt + {31'd0, done_out};
    end
  assign cycle_cnt_out  = r_cycle_cnt;
  assign retire_cnt_out = r_retire_cnt;
`else
  assign cycle_cnt_out  = 32'd0;
  assign retire_cnt_out = 32'd0;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
  localparam logic [5:0] ADDU = 6'd1, SUBU = 6'd2, JR = 6'd3, SLL = 6'd4, ORI = 6'd5;
  localparam logic [5:0] LW = 6'd6, SW = 6'd7, BEQ = 6'd8, LUI = 6'd9, JAL = 6'd10, UNK = 6'h3F;
  logic clk = 1'b0, reset = 1'b1, zero_in = 1'b0, mem_ack_in = 1'b1;
  logic [5:0] instrCode_in = 6'd0;
  logic mem_req_out, mem_we_out, pcWrite_out, irWrite_out, regWrite_out, aluSrc_out, extOp_out, done_out;
  logic [1:0] pcSrc_out, regDst_out, memToReg_out;
  logic [2:0] aluOp_out, state_out;
  logic [31:0] cycle_cnt_out, retire_cnt_out;
  int checks = 0, errors = 0, n_done = 0;
  int cyc, d0;
  logic [31:0] seq;
  logic [7:0] dec, ex, mem, wb;
  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .instrCode_in(instrCode_in), .zero_in(zero_in), .mem_ack_in(mem_ack_in),
    .mem_req_out(mem_req_out), .mem_we_out(mem_we_out), .pcWrite_out(pcWrite_out), .irWrite_out(irWrite_out),
    .regWrite_out(regWrite_out), .pcSrc_out(pcSrc_out), .regDst_out(regDst_out), .memToReg_out(memToReg_out),
    .aluSrc_out(aluSrc_out), .extOp_out(extOp_out), .aluOp_out(aluOp_out), .state_out(state_out),
    .done_out(done_out), .cycle_cnt_out(cycle_cnt_out), .retire_cnt_out(retire_cnt_out)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (done_out && !reset) n_done++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // snapshot of the outputs of interest: {pcWrite, regWrite, pcSrc, regDst, memToReg}
  function automatic logic [7:0] snap;
    return {pcWrite_out, regWrite_out, pcSrc_out, regDst_out, memToReg_out};
  endfunction
  task automatic run(input logic [5:0] code, input int fw, input int mw, input logic z);
    int f = 0, m = 0;
    logic d = 1'b0;
    cyc = 0; seq = 0; dec = 0; ex = 0; mem = 0; wb = 0;
    instrCode_in = code;
    zero_in = z;
    for (int k = 0; k < 40 && !d; k++) begin
      mem_ack_in = (state_out == 3'd0) ? (f == fw) : (state_out == 3'd3) ? (m == mw) : 1'b0;
      #4;
      cyc++;
      seq = {seq[28:0], state_out};
      if (state_out == 3'd1) dec = snap();
      if (state_out == 3'd2) ex = {aluOp_out, aluSrc_out, extOp_out, pcWrite_out, pcSrc_out};
      if (state_out == 3'd3) mem = {aluOp_out, aluSrc_out, extOp_out, 2'b0, mem_we_out};
      if (state_out == 3'd4) wb = snap();
      if (state_out == 3'd0) f++;
      if (state_out == 3'd3) m++;
      d = done_out;
      tick();
    end
    mem_ack_in = 1'b0;
    if (!d) chk("timeout", 0, 1);
  endtask
  initial begin
    #2;
    chk("rst_state", state_out, 0);
    chk("rst_req", mem_req_out, 1);
    chk("rst_wr", {pcWrite_out, irWrite_out, regWrite_out, done_out}, 0);
    chk("rst_cnt", cycle_cnt_out | retire_cnt_out, 0);
    tick();
    #2 reset = 1'b0;
    mem_ack_in = 1'b0;
    tick();
    chk("first_fetch", {state_out, mem_req_out}, {3'd0, 1'b1});
    d0 = n_done;
    run(ADDU, 0, 0, 0);
    chk("addu_cyc", cyc, 4);
    chk("addu_seq", seq[11:0], 12'b000_001_010_100);
    chk("addu_wb", wb, 8'b0100_0100);
    chk("addu_done", n_done - d0, 1);
    run(LW, 2, 1, 0);
    chk("lw_cyc", cyc, 8);
    chk("lw_wb", wb, 8'b0100_0001);
    chk("lw_ex", ex, {3'd0, 1'b1, 1'b1, 1'b0, 2'd0});
    run(BEQ, 0, 0, 1);
    chk("beq1_cyc", cyc, 3);
    chk("beq1_ex", ex, {3'd1, 1'b0, 1'b0, 1'b1, 2'd1});
    run(BEQ, 0, 0, 0);
    chk("beq0_cyc", cyc, 3);
    chk("beq0_ex", ex, {3'd1, 1'b0, 1'b0, 1'b0, 2'd1});
    run(JAL, 0, 0, 0);
    chk("jal_cyc", cyc, 2);
    chk("jal_dec", dec, 8'b1110_1010);
    run(JR, 1, 0, 0);
    chk("jr_cyc", cyc, 3);
    chk("jr_dec", dec, 8'b1011_0000);
    run(UNK, 0, 0, 0);
    chk("unk_cyc", cyc, 2);
    chk("unk_dec", dec, 0);
    run(ORI, 0, 0, 0);
    chk("ori_ex", ex[7:3], {3'd2, 1'b1, 1'b0});
    chk("ori_wb", wb, 8'b0100_0000);
    run(LUI, 0, 0, 0);
    chk("lui_ex", ex[7:3], {3'd3, 1'b1, 1'b0});
    run(SLL, 0, 0, 0);
    chk("sll_ex", ex[7:3], {3'd4, 1'b0, 1'b0});
    chk("sll_wb", wb, 8'b0100_0100);
    run(SUBU, 0, 0, 0);
    chk("subu_wb", {ex[7:5], wb}, {3'd1, 8'b0100_0100});
    run(SW, 0, 2, 0);
    chk("sw_cyc", cyc, 6);
    chk("sw_mem", mem, {3'd0, 1'b1, 1'b1, 3'b001});
    chk("sw_seq", seq[17:0], 18'b000_001_010_011_011_011);
    // reset in the middle of a sw data access with the ack pending
    instrCode_in = SW;
    mem_ack_in = 1'b1;
    tick();
    mem_ack_in = 1'b0;
    tick();
    tick();
    chk("pre_rst_mem", {state_out, mem_we_out}, {3'd3, 1'b1});
    d0 = n_done;
    mem_ack_in = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("rst_mem_state", state_out, 0);
    chk("rst_mem_we", {mem_we_out, pcWrite_out, irWrite_out, regWrite_out, done_out}, 0);
    tick();
    mem_ack_in = 1'b0;
    #2 reset = 1'b0;
    #2;
    chk("rst_mem_after", {state_out, pcWrite_out, regWrite_out, mem_we_out}, 0);
    tick();
    chk("rst_mem_nodone", n_done - d0, 0);
    // counters measured from a fresh reset over ten back-to-back zero-wait addu
    reset = 1'b1;
    #2 reset = 1'b0;
    for (int i = 0; i < 10; i++) run(ADDU, 0, 0, 0);
`ifdef MULTICYCLE_CTRL_PERF_EN
    chk("perf_retire", retire_cnt_out, 10);
    chk("perf_cycle", cycle_cnt_out, 40);
`else
    chk("perf_retire", retire_cnt_out, 0);
    chk("perf_cycle", cycle_cnt_out, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
